uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a receive FIFO, the successor to the single-byte receiver in the host-link path.
- Samples the asynchronous `rx` line through a 2-flop synchroniser and qualifies each bit with a 3-sample majority vote.
- Supports none/even/odd parity and 1 or 2 stop bits.
- Buffers received words in a small FIFO with a ready/valid consumer handshake.
- Reports parity, framing, overrun and line-break conditions as sticky flags.
- Sits between the board RX pin and the command decoder.

## Interface
- `C_CLK_FRQ`, 100000000: clock frequency [Hz].
- `C_UART_RATE`, 1000000: baud rate. `C_PERIOD = C_CLK_FRQ / C_UART_RATE` must be at least 8; otherwise elaboration fails.
- `C_UART_DATA_WIDTH`, 8: data bits per word, 5..9, LSB first on the line.
- `C_UART_PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `C_UART_STOP`, 1: stop bits, 1 or 2.
- `C_FIFO_DEPTH`, 4: FIFO entries, a power of 2, at least 2.
- `clk`  in  1  master clock. All logic runs in this single clock domain.
- `rstb`  in  1  reset, asynchronous, active low.
- `rx`  in  1  asynchronous serial line, idle high.
- `data`  out  C_UART_DATA_WIDTH  FIFO head word.
- `valid`  out  1  FIFO not empty; `data` is meaningful.
- `ready`  in  1  consumer accepts `data` on a cycle where `valid && ready`.
- `level`  out  $clog2(C_FIFO_DEPTH+1)  current FIFO occupancy.
- `err_parity`, `err_frame`, `err_overrun`, `brk`  out  1 each  sticky status flags.
- `clear`  in  1  synchronous clear of all four sticky flags.

## Operation
- Synchroniser: 2 flops on `rx`, both reset to 1. `rxs` is the synchronised value.
- Bit timer: `tmr` counts 0..C_PERIOD-1.
- Sampling: for each bit, samples are taken at `tmr` = H-1, H and H+1, where H = C_PERIOD/2. The majority vote of the three is registered at H+1; this is the *decision cycle*.
- FSM states: sIDLE, sSTART, sDATA, sPARITY, sSTOP, sBREAK, sPUSH.
- **sIDLE**
  - `tmr` = 0, bit counter = 0.
  - When `rxs` = 0, go to sSTART.
- **sSTART**
  - If the vote is 1, the start is false: return to sIDLE with nothing pushed and no flag set.
  - If the vote is 0, go to sDATA and restart `tmr` so that each later decision falls exactly C_PERIOD cycles after the previous one.
- **sDATA**
  - Shift the voted bits into a register, LSB first.
  - After C_UART_DATA_WIDTH bits, go to sPARITY if parity is enabled, else sSTOP.
- **sPARITY**
  - Expected parity bit is ^data for even parity and ~^data for odd parity.
  - On a mismatch, latch the local flag `perr`.
- **sSTOP**
  - Check C_UART_STOP bits; any stop vote of 0 latches the local flag `ferr`.
  - Break condition: data bits, parity bit (if present) and stop bits all 0. On break, set `brk` and go to sBREAK.
  - Otherwise go to sPUSH at the last stop decision.
- **sBREAK**: no push. Stay until `rxs` = 1, then go to sIDLE.
- **sPUSH** (1 cycle)
  - If `perr`: set `err_parity`, drop the word.
  - Else if `ferr`: set `err_frame`, drop the word.
  - Else if the FIFO is full and no pop happens this cycle: set `err_overrun`, drop the word.
  - Else write the word into the FIFO.
  - Then go to sIDLE; `perr` and `ferr` clear on entry to sIDLE.
- FIFO
  - `data` shows the head word; `valid` = (`level` != 0).
  - A pop occurs on `valid && ready`.
  - Simultaneous push and pop: both take effect, `level` is unchanged. This holds when full, so a full FIFO with a pop in the push cycle takes no overrun.
  - Pointers wrap modulo C_FIFO_DEPTH.
  - `ready` while empty has no effect.
- Sticky flags: set by their event and cleared by `clear`. If `clear` and a set event occur in the same cycle, the set wins.
- Reset mid-frame abandons the frame. The FIFO contents are lost.

## Timing
- Reset values: `data` = 0, `valid` = 0, `level` = 0, all flags 0, FSM in sIDLE, synchroniser = 1.
- Start detection latency: 2 cycles from the `rx` fall to `rxs` = 0.
- Word latency:
  - Last stop decision at edge N.
  - sPUSH during cycle N..N+1; the FIFO write is at edge N+1.
  - `valid` and `level` update at N+1, i.e. visible from cycle N+1.
  - The FSM is in sIDLE from N+1, so it accepts a start bit arriving in the second half of the stop bit.
- Pop: `level` decrements and `data` advances at the edge where `valid && ready` is sampled.
- Error flags assert at the edge ending sPUSH. `brk` asserts at the edge ending the last stop decision.

## Structure
- Package `uart_pkg`: the parity encoding constants (NONE/EVEN/ODD), the FSM state encoding, and a function that checks that C_PERIOD is at least 8.
- Sub-module `uart_fifo`: synchronous FIFO with parameters for width and depth, ports push/pop/full/empty/level, async active-low reset.
- The top level holds the synchroniser, bit timer, vote logic and FSM.

## Test plan
All scenarios use C_PERIOD = 100, with even parity and C_FIFO_DEPTH = 4 unless stated.
- Send 0xA5 with parity 0 and 1 stop bit -> `valid` = 1, `data` = 0xA5, `level` = 1, all flags 0. Pulse `ready` -> `level` = 0.
- Send 0x3C with parity bit 1 (wrong) -> `err_parity` = 1, `level` = 0. Pulse `clear` -> flag = 0.
- Send 0x55 with stop bit 0 -> `err_frame` = 1, no push. The next 0x12 is received correctly.
- Hold `rx` low for 30 cycles, then high -> FSM returns to sIDLE, nothing pushed, no flags. Separately, a single-cycle glitch at sample H mid-bit on 0xF0 -> still received as 0xF0.
- Send 0x01..0x05 with `ready` = 0 -> `level` = 4, `err_overrun` = 1, `data` = 0x01. Popping 4 times yields 0x01, 0x02, 0x03, 0x04.
- Hold `rx` low for 12 bit times -> `brk` = 1, `level` = 0. Then `rx` high, then send 0x7E -> `data` = 0x7E. Separately, assert `rstb` low mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encoding, FSM states,
// and the elaboration-time bit-period check.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    sIDLE,
    sSTART,
    sDATA,
    sPARITY,
    sSTOP,
    sBREAK,
    sPUSH
  } state_t;

  function automatic bit period_ok(input int unsigned period);
    return period >= 8;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO holding received words; head word is always visible
// on rdata, and simultaneous push/pop is legal even when full.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// parity/stop checking, break detection, and a receive FIFO with sticky flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned C_CLK_FRQ         = 100000000,
  parameter int unsigned C_UART_RATE       = 1000000,
  parameter int unsigned C_UART_DATA_WIDTH = 8,
  parameter int unsigned C_UART_PARITY     = 0,
  parameter int unsigned C_UART_STOP       = 1,
  parameter int unsigned C_FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              rx,
  output logic [C_UART_DATA_WIDTH-1:0]      data,
  output logic                              valid,
  input  logic                              ready,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0] level,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              err_overrun,
  output logic                              brk,
  input  logic                              clear
);

  localparam int unsigned C_PERIOD = C_CLK_FRQ / C_UART_RATE;
  localparam int unsigned H        = C_PERIOD / 2;
  localparam int unsigned TW       = $clog2(C_PERIOD);
  localparam int unsigned CW       = $clog2(C_UART_DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_LO   = TW'(H - 1);
  localparam logic [TW-1:0] T_MID  = TW'(H);
  localparam logic [TW-1:0] T_DEC  = TW'(H + 1);
  localparam logic [TW-1:0] T_LAST = TW'(C_PERIOD - 1);

  if (!period_ok(C_PERIOD)) begin : g_period_check
    $error("uart_rx_fifo: C_CLK_FRQ / C_UART_RATE must be at least 8");
  end

  state_t                         state, state_nxt;
  logic                           sync1, rxs;
  logic [TW-1:0]                  tmr;
  logic                           smp0, smp1;
  logic                           vote, decide;
  logic [CW-1:0]                  bit_cnt;
  logic                           last_data, last_stop;
  logic [C_UART_DATA_WIDTH-1:0]   shreg;
  logic                           par_exp;
  logic                           perr, ferr, zero;
  logic                           full, empty, pop, push;
  logic                           set_par, set_frm, set_ovr, set_brk;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Free-running modulo-C_PERIOD timer keeps every decision exactly one period
  // after the previous one, starting from the start-bit decision.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                   tmr <= '0;
    else if (state == sIDLE)     tmr <= '0;
    else if (tmr == T_LAST)      tmr <= '0;
    else                         tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (tmr == T_LO)  smp0 <= rxs;
      if (tmr == T_MID) smp1 <= rxs;
    end
  end

  assign vote      = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  assign decide    = (state != sIDLE) && (tmr == T_DEC);
  assign last_data = (bit_cnt == CW'(C_UART_DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == CW'(C_UART_STOP - 1));
  assign par_exp   = (C_UART_PARITY == PAR_ODD) ? ~^shreg : ^shreg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= sIDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      sIDLE:   if (!rxs) state_nxt = sSTART;
      sSTART:  if (decide) state_nxt = vote ? sIDLE : sDATA;
      sDATA:   if (decide && last_data)
                 state_nxt = (C_UART_PARITY != PAR_NONE) ? sPARITY : sSTOP;
      sPARITY: if (decide) state_nxt = sSTOP;
      sSTOP:   if (decide && last_stop)
                 state_nxt = (zero && !vote) ? sBREAK : sPUSH;
      sBREAK:  if (rxs) state_nxt = sIDLE;
      sPUSH:   state_nxt = sIDLE;
      default: state_nxt = sIDLE;
    endcase
  end

  // zero tracks whether every data, parity and stop vote so far was 0.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      zero    <= 1'b1;
      bit_cnt <= '0;
    end else begin
      case (state)
        sIDLE: begin
          perr    <= 1'b0;
          ferr    <= 1'b0;
          zero    <= 1'b1;
          bit_cnt <= '0;
        end
        sDATA: if (decide) begin
          shreg   <= {vote, shreg[C_UART_DATA_WIDTH-1:1]};
          zero    <= zero & ~vote;
          bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
        end
        sPARITY: if (decide) begin
          zero <= zero & ~vote;
          if (vote != par_exp) perr <= 1'b1;
        end
        sSTOP: if (decide) begin
          zero    <= zero & ~vote;
          bit_cnt <= bit_cnt + 1'b1;
          if (!vote) ferr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pop     = valid && ready;
  assign set_par = (state == sPUSH) && perr;
  assign set_frm = (state == sPUSH) && !perr && ferr;
  assign set_ovr = (state == sPUSH) && !perr && !ferr && full && !pop;
  assign push    = (state == sPUSH) && !perr && !ferr && (!full || pop);
  assign set_brk = (state == sSTOP) && decide && last_stop && zero && !vote;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
      brk         <= 1'b0;
    end else begin
      err_parity  <= set_par | (err_parity  & ~clear);
      err_frame   <= set_frm | (err_frame   & ~clear);
      err_overrun <= set_ovr | (err_overrun & ~clear);
      brk         <= set_brk | (brk         & ~clear);
    end
  end

  uart_fifo #(
    .WIDTH (C_UART_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .pop   (pop),
    .wdata (shreg),
    .rdata (data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign valid = !empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo (C_PERIOD = 100, even parity,
// 1 stop bit, depth 4) checked against a word-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int BIT   = 100;

  logic       clk = 1'b0;
  logic       rstb, rx, ready, clear;
  logic [7:0] data;
  logic       valid;
  logic [2:0] level;
  logic       err_parity, err_frame, err_overrun, brk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit m_par, m_frm, m_ovr, m_brk;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .C_CLK_FRQ         (100000000),
    .C_UART_RATE       (1000000),
    .C_UART_DATA_WIDTH (8),
    .C_UART_PARITY     (1),
    .C_UART_STOP       (1),
    .C_FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .ready       (ready),
    .level       (level),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overrun (err_overrun),
    .brk         (brk),
    .clear       (clear)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
    check({tag, ".level"}, 32'(level), 32'(q.size()));
    if (q.size() != 0) check({tag, ".data"}, 32'(data), 32'(q[0]));
    check({tag, ".err_parity"},  32'(err_parity),  32'(m_par));
    check({tag, ".err_frame"},   32'(err_frame),   32'(m_frm));
    check({tag, ".err_overrun"}, 32'(err_overrun), 32'(m_ovr));
    check({tag, ".brk"},         32'(brk),         32'(m_brk));
  endtask

  // Word-level model: one finished frame -> one outcome, in priority order.
  task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit stop_val,
                             input bit pop_in_push);
    bit par;
    par = (^d) ^ bad_par;
    if (d == 8'h00 && !par && !stop_val) m_brk = 1'b1;
    else if (bad_par)                    m_par = 1'b1;
    else if (!stop_val)                  m_frm = 1'b1;
    else begin
      if (pop_in_push && q.size() != 0) void'(q.pop_front());
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else                   q.push_back(d);
    end
  endtask

  // Bit 0 is the start bit; glitch inverts rx for one cycle at the bit centre,
  // pop_off raises ready for one cycle at that offset into the stop bit.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_val,
                            input int glitch_bit, input int pop_off);
    logic [10:0] bits;
    bits = {stop_val, (^d) ^ bad_par, d, 1'b0};
    for (int b = 0; b < 11; b++)
      for (int c = 0; c < BIT; c++) begin
        rx = (b == glitch_bit && c == BIT / 2) ? ~bits[b] : bits[b];
        if (pop_off >= 0) ready = (b == 10 && c == pop_off);
        @(negedge clk);
      end
    rx    = 1'b1;
    ready = 1'b0;
    repeat (BIT) @(negedge clk);
    model_frame(d, bad_par, stop_val, pop_off >= 0);
  endtask

  task automatic pop_word(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(1));
    check({tag, ".data"},  32'(data),  32'(q[0]));
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    void'(q.pop_front());
    check({tag, ".level"}, 32'(level), 32'(q.size()));
  endtask

  task automatic clear_flags(input string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_par = 0; m_frm = 0; m_ovr = 0; m_brk = 0;
    check_all(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b0; rx = 1'b1; ready = 1'b0; clear = 1'b0;
    repeat (5) @(negedge clk);
    check_all("reset");
    check("reset.data", 32'(data), 32'(0));
    rstb = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'hA5, 0, 1, -1, -1);
    check_all("a5");
    pop_word("a5_pop");

    send_frame(8'h3C, 1, 1, -1, -1);
    check_all("bad_parity");
    clear_flags("clear_parity");

    send_frame(8'h55, 0, 0, -1, -1);
    check_all("bad_stop");
    send_frame(8'h12, 0, 1, -1, -1);
    check_all("after_frame_err");
    pop_word("12_pop");
    clear_flags("clear_frame");

    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_all("false_start");

    send_frame(8'hF0, 0, 1, 5, -1);
    check_all("glitch");
    pop_word("f0_pop");

    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, -1, -1);
    check_all("full");
    send_frame(8'h05, 0, 1, -1, -1);
    check_all("overrun");
    check("overrun.head", 32'(data), 32'h01);
    clear_flags("clear_overrun");
    send_frame(8'h06, 0, 1, -1, 55);
    check_all("full_push_pop");
    for (int i = 0; i < 4; i++) pop_word("drain");

    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    m_brk = 1'b1;
    check_all("break");
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h7E, 0, 1, -1, -1);
    check_all("after_break");
    pop_word("7e_pop");
    clear_flags("clear_break");

    send_frame(8'h33, 0, 1, -1, -1);
    send_frame(8'h44, 1, 1, -1, -1);
    check_all("pre_reset");
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    q.delete();
    m_par = 0; m_frm = 0; m_ovr = 0; m_brk = 0;
    check_all("mid_reset");
    check("mid_reset.data", 32'(data), 32'(0));
    rstb = 1'b1;
    rx   = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h81, 0, 1, -1, -1);
    check_all("after_reset");
    pop_word("81_pop");

    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      bit bp, bs;
      d  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) != 0);
      if (q.size() != 0 && $urandom_range(0, 2) == 0) pop_word("rnd_pop");
      send_frame(d, bp, bs, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1, -1);
      check_all("rnd");
      if ($urandom_range(0, 3) == 0) clear_flags("rnd_clear");
    end
    while (q.size() != 0) pop_word("rnd_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
